neuron_mac_q16: RTL and testbench

Single-neuron multiply-accumulate stage that sits directly upstream of the sigmoid activation block. It consumes a stream of N_INPUTS signed activation/weight pairs and adds a bias. It produces the pre-activation sum as a saturated signed 32-bit Q16.16 word, which drives the sigmoid's 32-bit x input. The result is held stable until the next operation completes.

---
 rtl/neuron_mac_q16.sv | 134 +++++++++++++
 tb/tb_neuron_mac_q16.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_q16.sv
// Single-neuron multiply-accumulate stage feeding the sigmoid block: sums N_INPUTS
// signed Q8.8 act*wgt products plus a Q16.16 bias, then saturates to a signed Q16.16 word.
module neuron_mac_q16 #(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic [15:0] act,
  input  logic [15:0] wgt,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] x_out,
  output logic        out_valid,
  output logic        sat,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    SAT   = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(N_INPUTS - 1);
  // Q16.16 representable range expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-32){1'b1}}, 32'h8000_0000};

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [31:0]               bias_q, bias_d;
  logic [31:0]               x_out_q, x_out_d;
  logic                      sat_q, sat_d;
  logic                      out_valid_q, out_valid_d;

  logic signed [31:0]        act_s, wgt_s, prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s, bias_ext_s;

  // Operands are sign-extended to 32 bits so the truncated product is the exact 16x16 result.
  assign act_s      = {{16{act[15]}}, act};
  assign wgt_s      = {{16{wgt[15]}}, wgt};
  assign prod_s     = act_s * wgt_s;
  assign prod_ext_s = {{(ACC_W-32){prod_s[31]}}, prod_s};
  assign bias_ext_s = {{(ACC_W-32){bias_q[31]}}, bias_q};

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign x_out     = x_out_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bias_d      = bias_q;
    x_out_d     = x_out_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bias_d  = bias;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = 8'd0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + prod_ext_s;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = BIAS;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      BIAS: begin
        acc_d   = acc_q + bias_ext_s;
        state_d = SAT;
      end
      SAT: begin
        if (acc_q > SAT_MAX) begin
          x_out_d = 32'h7FFF_FFFF;
          sat_d   = 1'b1;
        end else if (acc_q < SAT_MIN) begin
          x_out_d = 32'h8000_0000;
          sat_d   = 1'b1;
        end else begin
          x_out_d = acc_q[31:0];
          sat_d   = 1'b0;
        end
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset abandons any evaluation in flight; x_out/sat otherwise persist until the next SAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= 8'd0;
      bias_q      <= 32'd0;
      x_out_q     <= 32'd0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bias_q      <= bias_d;
      x_out_q     <= x_out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac_q16.sv
// Directed bench for neuron_mac_q16 (N_INPUTS=4): expected results are queued at start
// and compared when out_valid pulses.
module tb_neuron_mac_q16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] bias;
  logic [15:0] act;
  logic [15:0] wgt;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_out;
  logic        out_valid;
  logic        sat;
  logic        busy;

  typedef struct packed {
    logic [31:0] x;
    logic        s;
  } exp_t;

  exp_t sb[$];
  int   total      = 0;
  int   passed     = 0;
  int   push_count = 0;
  int   ov_count   = 0;
  int   cyc        = 0;
  int   start_cyc  = 0;
  int   ov_cyc     = 0;
  logic prev_ov    = 1'b0;

  neuron_mac_q16 #(.N_INPUTS(4), .ACC_W(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .act(act), .wgt(wgt),
    .in_valid(in_valid), .in_ready(in_ready), .x_out(x_out), .out_valid(out_valid),
    .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      ov_count++;
      ov_cyc = cyc;
      chk("ov_single_cycle", {31'd0, prev_ov}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, {31'd0, out_valid ^ 1'b1});
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("x_out", x_out, e.x);
        chk("sat", {31'd0, sat}, {31'd0, e.s});
      end
    end
    prev_ov = out_valid;
  end

  task automatic do_start(input logic [31:0] b, input logic [31:0] ex, input logic es);
    sb.push_back({ex, es});
    push_count++;
    bias      = b;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    bias  = 32'hDEAD_BEEF;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic feed(input logic [15:0] a, input logic [15:0] w, input bit gaps, input bit hold_start);
    int sent = 0;
    int k    = 0;
    while (sent < 4) begin
      if (gaps && (k % 2 == 1)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        act      = a;
        wgt      = w;
      end
      start = hold_start;
      chk("in_ready_accum", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      if (in_valid) sent++;
      k++;
    end
    in_valid = 1'b0;
    act      = 16'h0000;
    wgt      = 16'h0000;
    if (hold_start) begin
      chk("in_ready_bias", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic wait_done(input bit check_lat);
    int target = push_count;
    for (int i = 0; i < 40 && ov_count < target; i++) @(negedge clk);
    chk("done_within_budget", ov_count, target);
    if (check_lat) chk("latency", ov_cyc - start_cyc, 32'd7);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bias = 32'd0; act = 16'd0; wgt = 16'd0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x_out", x_out, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 4 x (1.0 * 1.0) = 4.0
    do_start(32'd0, 32'h0004_0000, 1'b0);
    feed(16'h0100, 16'h0100, 1'b0, 1'b0);
    wait_done(1'b1);

    // 4 x (0.5 * -1.0) + 1.0 = -1.0, continuous then gapped
    do_start(32'h0001_0000, 32'hFFFF_0000, 1'b0);
    feed(16'h0080, 16'hFF00, 1'b0, 1'b0);
    wait_done(1'b1);
    do_start(32'h0001_0000, 32'hFFFF_0000, 1'b0);
    feed(16'h0080, 16'hFF00, 1'b1, 1'b0);
    wait_done(1'b0);

    // Positive and negative saturation
    do_start(32'd0, 32'h7FFF_FFFF, 1'b1);
    feed(16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
    wait_done(1'b1);
    do_start(32'd0, 32'h8000_0000, 1'b1);
    feed(16'h8000, 16'h7FFF, 1'b0, 1'b0);
    wait_done(1'b1);

    // start held while busy, then in_valid driven while idle
    do_start(32'd0, 32'h0004_0000, 1'b0);
    feed(16'h0100, 16'h0100, 1'b0, 1'b1);
    wait_done(1'b1);
    in_valid = 1'b1; act = 16'h7FFF; wgt = 16'h7FFF;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    chk("idle_x_hold", x_out, 32'h0004_0000);

    // Abort after two pairs
    bias = 32'h0001_0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; act = 16'h0100; wgt = 16'h0100;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_x_out", x_out, 32'd0);
    chk("abort_sat", {31'd0, sat}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(32'd0, 32'h0004_0000, 1'b0);
    feed(16'h0100, 16'h0100, 1'b0, 1'b0);
    wait_done(1'b1);

    // Back-to-back: second start in the out_valid cycle of the first
    do_start(32'd0, 32'h0004_0000, 1'b0);
    feed(16'h0100, 16'h0100, 1'b0, 1'b0);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (out_valid === 1'b1) found = 1'b1;
      end
      chk("b2b_first_ov", {31'd0, found}, 32'd1);
    end
    sb.push_back({32'h0008_0000, 1'b0});
    push_count++;
    bias = 32'd0; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    feed(16'h0100, 16'h0200, 1'b0, 1'b0);
    chk("b2b_x_held", x_out, 32'h0004_0000);
    wait_done(1'b1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("ov_total", ov_count, push_count);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
